// File: rtl/lib_cnt_pkg.sv
// ============================================================================
// Module   : lib_cnt_pkg
// Purpose  : Shared mode encodings and NAND/INV cell helpers for the
//            up/down counter library cell and control-unit decoders.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lib_cnt_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

  // Cell models so every gate in the slice maps 1:1 onto a library cell
  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

  function automatic logic inv(input logic a);
    return ~a;
  endfunction

endpackage : lib_cnt_pkg

`default_nettype wire

// File: rtl/lib_cnt_slice.sv
// ============================================================================
// Module   : lib_cnt_slice
// Purpose  : One counter bit: flip-flop, NAND-built toggle/load/hold mux and
//            up/down propagate chain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lib_cnt_slice
  import lib_cnt_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic is_load_i,
  input  logic is_up_i,
  input  logic is_dn_i,
  input  logic en_i,
  input  logic d_i,
  input  logic up_prop_i,
  input  logic dn_prop_i,
  output logic q_o,
  output logic up_prop_o,
  output logic dn_prop_o
);

  logic bit_q;
  logic bit_d;

  logic w_n_up;
  logic w_n_dn;
  logic w_dir;
  logic w_tog;
  logic w_x_n;
  logic w_flip;
  logic w_n_ld;
  logic w_n_keep;

  // Toggle when the selected direction's lower bits all propagate and the
  // stage is enabled; HOLD leaves both directions deselected.
  assign w_n_up = nand2(is_up_i, up_prop_i);
  assign w_n_dn = nand2(is_dn_i, dn_prop_i);
  assign w_dir  = nand2(w_n_up, w_n_dn);
  assign w_tog  = inv(nand2(w_dir, en_i));

  // Four-NAND XOR: bit_q ^ w_tog
  assign w_x_n  = nand2(bit_q, w_tog);
  assign w_flip = nand2(nand2(bit_q, w_x_n), nand2(w_tog, w_x_n));

  // Load mux: LOAD takes d, otherwise the (possibly toggled) current bit
  assign w_n_ld   = nand2(is_load_i, d_i);
  assign w_n_keep = nand2(inv(is_load_i), w_flip);
  assign bit_d    = nand2(w_n_ld, w_n_keep);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_q <= RST_BIT;
    end else begin
      bit_q <= bit_d;
    end
  end

  // Propagate chains are ungated so the final stage doubles as the
  // all-ones / all-zeros detector for terminal count.
  assign up_prop_o = inv(nand2(up_prop_i, bit_q));
  assign dn_prop_o = inv(nand2(dn_prop_i, inv(bit_q)));

  assign q_o = bit_q;

endmodule : lib_cnt_slice

`default_nettype wire

// File: rtl/lib_updown_counter.sv
// ============================================================================
// Module   : lib_updown_counter
// Purpose  : N-bit synchronous up/down counter with load, hold, terminal count,
//            optional saturation and ripple-carry chaining.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lib_updown_counter
  import lib_cnt_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0,
  parameter bit          WRAP      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             cin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             cout
);

  localparam logic [31:0]      c_reset_full = 32'(RESET_VAL);
  localparam logic [WIDTH-1:0] c_reset      = c_reset_full[WIDTH-1:0];

  logic             w_is_load;
  logic             w_is_up;
  logic             w_is_dn;
  logic             w_sat;
  logic             w_en;
  logic [WIDTH:0]   w_up_prop;
  logic [WIDTH:0]   w_dn_prop;
  logic [WIDTH-1:0] w_q;

  assign w_is_load = (mode == MODE_LOAD);
  assign w_is_up   = (mode == MODE_UP);
  assign w_is_dn   = (mode == MODE_DOWN);

  assign w_up_prop[0] = 1'b1;
  assign w_dn_prop[0] = 1'b1;

  // Chain tails equal &q and ~|q respectively
  assign tc   = (w_is_up & w_up_prop[WIDTH]) | (w_is_dn & w_dn_prop[WIDTH]);
  assign cout = tc & cin;

  // In saturate mode the limit blocks the toggle, but cout still follows cin
  assign w_sat = (WRAP == 1'b0) & tc;
  assign w_en  = cin & ~w_sat;

  generate
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_slice
      lib_cnt_slice #(
        .RST_BIT (c_reset[i])
      ) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .is_load_i (w_is_load),
        .is_up_i   (w_is_up),
        .is_dn_i   (w_is_dn),
        .en_i      (w_en),
        .d_i       (d[i]),
        .up_prop_i (w_up_prop[i]),
        .dn_prop_i (w_dn_prop[i]),
        .q_o       (w_q[i]),
        .up_prop_o (w_up_prop[i+1]),
        .dn_prop_o (w_dn_prop[i+1])
      );
    end
  endgenerate

  assign q = w_q;

endmodule : lib_updown_counter

`default_nettype wire

// File: tb/tb_lib_updown_counter.sv
// ============================================================================
// Module   : tb_lib_updown_counter
// Purpose  : Directed self-checking bench for lib_updown_counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lib_updown_counter;
  import lib_cnt_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Group A: WIDTH=4, RESET_VAL=5, wrapping
  logic       a_rst_n, a_cin, a_tc, a_cout;
  logic [1:0] a_mode;
  logic [3:0] a_d, a_q;
  // Group S: WIDTH=4, RESET_VAL=0, saturating
  logic       s_rst_n, s_cin, s_tc, s_cout;
  logic [1:0] s_mode;
  logic [3:0] s_d, s_q;
  // Chain: two WIDTH=4 wrapping stages
  logic       ch_rst_n, ch_cin, c0_tc, c0_cout, c1_tc, c1_cout;
  logic [1:0] ch_mode;
  logic [7:0] ch_d;
  logic [3:0] c0_q, c1_q;
  // Exhaustive: WIDTH=3, both wrap settings driven identically
  logic       x_rst_n, x_cin, x0_tc, x0_cout, x1_tc, x1_cout;
  logic [1:0] x_mode;
  logic [2:0] x_d, x0_q, x1_q;

  lib_updown_counter #(.WIDTH(4), .RESET_VAL(5), .WRAP(1'b1)) u_a (
    .clk(clk), .rst_n(a_rst_n), .mode(a_mode), .cin(a_cin), .d(a_d),
    .q(a_q), .tc(a_tc), .cout(a_cout));

  lib_updown_counter #(.WIDTH(4), .RESET_VAL(0), .WRAP(1'b0)) u_s (
    .clk(clk), .rst_n(s_rst_n), .mode(s_mode), .cin(s_cin), .d(s_d),
    .q(s_q), .tc(s_tc), .cout(s_cout));

  lib_updown_counter #(.WIDTH(4), .RESET_VAL(0), .WRAP(1'b1)) u_c0 (
    .clk(clk), .rst_n(ch_rst_n), .mode(ch_mode), .cin(ch_cin), .d(ch_d[3:0]),
    .q(c0_q), .tc(c0_tc), .cout(c0_cout));

  lib_updown_counter #(.WIDTH(4), .RESET_VAL(0), .WRAP(1'b1)) u_c1 (
    .clk(clk), .rst_n(ch_rst_n), .mode(ch_mode), .cin(c0_cout), .d(ch_d[7:4]),
    .q(c1_q), .tc(c1_tc), .cout(c1_cout));

  lib_updown_counter #(.WIDTH(3), .RESET_VAL(0), .WRAP(1'b0)) u_x0 (
    .clk(clk), .rst_n(x_rst_n), .mode(x_mode), .cin(x_cin), .d(x_d),
    .q(x0_q), .tc(x0_tc), .cout(x0_cout));

  lib_updown_counter #(.WIDTH(3), .RESET_VAL(0), .WRAP(1'b1)) u_x1 (
    .clk(clk), .rst_n(x_rst_n), .mode(x_mode), .cin(x_cin), .d(x_d),
    .q(x1_q), .tc(x1_tc), .cout(x1_cout));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the 3-bit exhaustive sweep
  function automatic logic [2:0] ref_next(input bit wrap, input logic [1:0] m,
                                          input logic [2:0] qv, input logic c,
                                          input logic [2:0] dv);
    logic [2:0] r;
    r = qv;
    case (m)
      MODE_LOAD: r = dv;
      MODE_UP:   if (c) r = (qv == 3'd7) ? (wrap ? 3'd0 : 3'd7) : qv + 3'd1;
      MODE_DOWN: if (c) r = (qv == 3'd0) ? (wrap ? 3'd7 : 3'd0) : qv - 3'd1;
      default:   r = qv;
    endcase
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    a_rst_n = 1'b0; a_mode = MODE_UP; a_cin = 1'b1; a_d = 4'd0;
    s_rst_n = 1'b0; s_mode = MODE_HOLD; s_cin = 1'b0; s_d = 4'd0;
    ch_rst_n = 1'b0; ch_mode = MODE_HOLD; ch_cin = 1'b1; ch_d = 8'h00;
    x_rst_n = 1'b0; x_mode = MODE_HOLD; x_cin = 1'b0; x_d = 3'd0;

    // Reset overrides UP/cin
    step();
    check_val("rst_q", 32'(a_q), 32'd5);
    check_val("rst_tc", 32'(a_tc), 32'd0);
    check_val("rst_s_q", 32'(s_q), 32'd0);
    a_rst_n = 1'b1; s_rst_n = 1'b1; ch_rst_n = 1'b1; x_rst_n = 1'b1;
    repeat (3) step();
    check_val("rst_run3", 32'(a_q), 32'd8);

    // Up wrap
    a_mode = MODE_LOAD; a_d = 4'd14;
    step();
    check_val("ld14", 32'(a_q), 32'd14);
    a_mode = MODE_UP; a_cin = 1'b1;
    #1;
    check_val("up14_tc", 32'(a_tc), 32'd0);
    step();
    check_val("up_q15", 32'(a_q), 32'd15);
    check_val("up_tc15", 32'(a_tc), 32'd1);
    check_val("up_cout15", 32'(a_cout), 32'd1);
    step();
    check_val("wrap_q0", 32'(a_q), 32'd0);
    check_val("wrap_tc0", 32'(a_tc), 32'd0);
    a_cin = 1'b0;
    repeat (2) step();
    check_val("cin0_hold", 32'(a_q), 32'd0);
    check_val("cin0_cout", 32'(a_cout), 32'd0);

    // Priority: reset beats LOAD, then LOAD and HOLD
    a_rst_n = 1'b0; a_mode = MODE_LOAD; a_d = 4'd9;
    step();
    check_val("prio_rst", 32'(a_q), 32'd5);
    a_rst_n = 1'b1;
    step();
    check_val("prio_ld9", 32'(a_q), 32'd9);
    a_mode = MODE_HOLD; a_cin = 1'b1;
    repeat (4) step();
    check_val("hold9", 32'(a_q), 32'd9);
    check_val("hold_tc", 32'(a_tc), 32'd0);

    // Down saturate
    s_mode = MODE_LOAD; s_d = 4'd1;
    step();
    check_val("sat_ld1", 32'(s_q), 32'd1);
    s_mode = MODE_DOWN; s_cin = 1'b1;
    #1;
    check_val("sat_tc1", 32'(s_tc), 32'd0);
    step();
    check_val("sat_q0a", 32'(s_q), 32'd0);
    check_val("sat_tc0a", 32'(s_tc), 32'd1);
    step();
    check_val("sat_q0b", 32'(s_q), 32'd0);
    check_val("sat_cout", 32'(s_cout), 32'd1);
    step();
    check_val("sat_q0c", 32'(s_q), 32'd0);
    s_mode = MODE_UP;
    #1;
    check_val("sat_up_tc", 32'(s_tc), 32'd0);
    step();
    check_val("sat_up_q1", 32'(s_q), 32'd1);
    s_mode = MODE_LOAD; s_d = 4'd15;
    step();
    s_mode = MODE_UP;
    step();
    check_val("sat_up_q15", 32'(s_q), 32'd15);
    check_val("sat_up_tc15", 32'(s_tc), 32'd1);

    // Chaining
    ch_mode = MODE_LOAD; ch_d = 8'h0E;
    step();
    check_val("ch_ld", 32'({c1_q, c0_q}), 32'h0E);
    ch_mode = MODE_UP;
    step();
    check_val("ch_0f", 32'({c1_q, c0_q}), 32'h0F);
    check_val("ch_c0cout", 32'(c0_cout), 32'd1);
    step();
    check_val("ch_10", 32'({c1_q, c0_q}), 32'h10);
    check_val("ch_c0cout0", 32'(c0_cout), 32'd0);
    step();
    check_val("ch_11", 32'({c1_q, c0_q}), 32'h11);
    ch_mode = MODE_LOAD; ch_d = 8'h10;
    step();
    ch_mode = MODE_DOWN;
    #1;
    check_val("ch_dn_cout", 32'(c0_cout), 32'd1);
    step();
    check_val("ch_dn_0f", 32'({c1_q, c0_q}), 32'h0F);

    // Exhaustive 3-bit sweep, both wrap settings in parallel
    for (int m = 0; m < 4; m++) begin
      for (int v = 0; v < 8; v++) begin
        for (int c = 0; c < 2; c++) begin
          logic [2:0] qv, dv, e0, e1;
          logic [1:0] mv;
          logic       cv, etc;
          qv = 3'(v); mv = 2'(m); cv = 1'(c); dv = ~qv;
          x_mode = MODE_LOAD; x_d = qv; x_cin = 1'b0;
          step();
          x_mode = mv; x_cin = cv; x_d = dv;
          #1;
          etc = ((mv == MODE_UP) && (qv == 3'd7)) || ((mv == MODE_DOWN) && (qv == 3'd0));
          check_val($sformatf("x_tc m%0d q%0d c%0d", m, v, c), 32'(x0_tc), 32'(etc));
          check_val($sformatf("x_cout m%0d q%0d c%0d", m, v, c), 32'(x1_cout), 32'(etc & cv));
          e0 = ref_next(1'b0, mv, qv, cv, dv);
          e1 = ref_next(1'b1, mv, qv, cv, dv);
          step();
          check_val($sformatf("x_sat m%0d q%0d c%0d", m, v, c), 32'(x0_q), 32'(e0));
          check_val($sformatf("x_wrap m%0d q%0d c%0d", m, v, c), 32'(x1_q), 32'(e1));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_lib_updown_counter

`default_nettype wire

// File: doc/lib_updown_counter.md
Name: lib_updown_counter

Overview:
- Parametrised synchronous up/down counter cell for the RV523 discrete-logic cell library.
- Used for the program-counter low bits, the shift-amount countdown and bus-timing dividers.
- Generalises the single-gate cells to an N-bit sequential block with four modes, terminal count and ripple-carry chaining.
- The netlist maps to library NAND cells plus one flip-flop per bit.

Parameters:
- WIDTH, 4, counter width in bits (1..16).
- RESET_VAL, 0, value loaded on reset; truncated to WIDTH bits.
- WRAP, 1, 1 = modulo-2^WIDTH wrap; 0 = saturate at all-ones (up) or zero (down).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- mode  input  2  00 HOLD, 01 LOAD, 10 UP, 11 DOWN.
- cin  input  1  count enable / carry-in from the previous stage; gates UP/DOWN only.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  registered count.
- tc  output  1  terminal count, combinational from q and mode.
- cout  output  1  carry-out, equal to tc AND cin; drives the next stage's cin.

Behaviour:
- Reset
  - rst_n=0 at a rising edge: q <= RESET_VAL. This overrides mode, cin and d.
  - tc and cout follow from the reset q and the current mode. There is no asynchronous path.
  - If reset is asserted mid-count, the count is lost and the next edge with rst_n=1 resumes from RESET_VAL.
- Per rising edge with rst_n=1
  - HOLD: q unchanged; cin ignored.
  - LOAD: q <= d; cin ignored. Loading takes effect in one cycle.
  - UP with cin=1: q <= q+1. At q = all-ones: WRAP=1 gives q <= 0; WRAP=0 keeps q at all-ones.
  - DOWN with cin=1: q <= q-1. At q = 0: WRAP=1 gives q <= all-ones; WRAP=0 keeps q at 0.
  - UP/DOWN with cin=0: q unchanged.
- Terminal count
  - tc=1 when mode=UP and q=all-ones, or when mode=DOWN and q=0.
  - tc=0 in HOLD and LOAD.
- Carry-out
  - cout = tc & cin, combinational.
  - Chaining rule: stage k+1 cin = stage k cout; all stages share mode. Two chained WIDTH=4 stages behave exactly as one WIDTH=8 counter.
- Latency: q reflects a command one cycle after it is sampled. tc and cout have zero latency relative to q and mode.
- Simultaneous events
  - Reset beats LOAD, and LOAD beats counting.
  - A mode change takes effect at the edge on which it is sampled; there is no pipeline.
- Arithmetic is unsigned and WIDTH-bit, with no overflow flag other than tc.
- In saturate mode at the limit, tc stays 1 and cout = cin. Downstream stages may therefore count; this is documented and intended, and chained saturation requires WRAP=1 on lower stages.
- Structural rule: the +1/-1 increment is a per-bit toggle, asserted when all lower bits are 1 (UP) or all 0 (DOWN) and the chain is enabled. It is built from NAND/INV cells only, with no behavioural adder.

Decomposition:
- Shared package lib_cnt_pkg holds the MODE_HOLD/LOAD/UP/DOWN 2-bit constants, used by the counter and by control-unit decoders.
- One sub-module, lib_cnt_slice, is a single bit containing:
  - the flip-flop;
  - the toggle/load/hold mux from NAND cells;
  - propagate-in and propagate-out for up and down.
- The top instantiates WIDTH slices, plus terminal-count and saturation gating.
- The expected top is around 150-250 lines including the slice.

Test Plan:
- Reset: WIDTH=4, RESET_VAL=5, rst_n=0 for one edge with mode=UP, cin=1 -> q=5, tc=0. Release and run 3 edges -> q=8.
- Up wrap: WRAP=1, LOAD d=14, then UP with cin=1:
  - edge 1 -> q=15, tc=1, cout=1;
  - edge 2 -> q=0, tc=0;
  - cin=0 for 2 edges -> q=0 held.
- Down saturate: WRAP=0, LOAD d=1, DOWN cin=1 for 3 edges -> q=1, 0, 0, 0 with tc=1 from q=0 onward; switching to UP -> tc=0 and the next edge gives q=1.
- Priority: same edge rst_n=0, mode=LOAD, d=9 -> q=RESET_VAL. Next edge rst_n=1, LOAD d=9 -> q=9. HOLD for 4 edges -> q=9.
- Chaining: two WIDTH=4 stages with stage0 cin=1, UP from LOAD 0x0E/0x00:
  - edges give 0x0F then 0x10;
  - stage1 increments only on the edge where stage0 cout=1.
  - Repeat DOWN from 0x10 -> 0x0F.
- Exhaustive: WIDTH=3, all 4 modes × 8 q values × cin × WRAP, compared against a reference model each cycle. This covers wrap and saturate for every combination.
